// File: rtl/pulse_qualifier_pkg.sv
// Shared types for the pad-input pulse qualifier: FSM state encoding and counter sizing.
package rgby_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } qualState_e;

  // Wide enough to hold the larger of the two run-length thresholds without wrapping.
  function automatic int cntWidth(input int minHigh, input int minLow);
    int maxRun;
    maxRun = (minHigh > minLow) ? minHigh : minLow;
    return $clog2(maxRun + 1);
  endfunction

endpackage

// File: rtl/pulse_qualifier_synchronizer.sv
// Multi-flop synchronizer for asynchronous pad levels; shared by other pad inputs.
module signal_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_qualifier.sv
// Turns a bouncy asynchronous level into one clk-domain strobe per qualified pulse.
// Optional width measurement is built when PULSE_QUALIFIER_WIDTH_MEASURE_EN is defined.
module pulse_qualifier
  import rgby_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 4,
  parameter int MIN_LOW     = 4
`ifdef PULSE_QUALIFIER_WIDTH_MEASURE_EN
  ,
  parameter int WIDTH_W     = 8
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               signal_in,
  input  logic               enable,
  output logic               pulse_out,
  output logic               glitch_out,
  output logic               busy
`ifdef PULSE_QUALIFIER_WIDTH_MEASURE_EN
  ,
  output logic [WIDTH_W-1:0] pulse_width,
  output logic               width_valid
`endif
);

  localparam int CW = cntWidth(MIN_HIGH, MIN_LOW);
  localparam logic [CW-1:0] MinHighC = CW'(MIN_HIGH);
  localparam logic [CW-1:0] MinLowC  = CW'(MIN_LOW);
  localparam logic [CW-1:0] CntOne   = CW'(1);

  logic          syncLevel;
  qualState_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          glitch_q, glitch_d;
  logic          busy_q;

  signal_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) uSync (
    .clk    (clk),
    .reset  (reset),
    .async_i(signal_in),
    .sync_o (syncLevel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      glitch_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      glitch_q <= glitch_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  // cnt holds the current run length of the level being qualified or released.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (syncLevel) begin
            state_d = QUALIFY;
            cnt_d   = CntOne;
          end
        end
        QUALIFY: begin
          if (!syncLevel) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == MinHighC) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        ACTIVE: begin
          if (!syncLevel) begin
            state_d = RELEASE;
            cnt_d   = CntOne;
          end
        end
        RELEASE: begin
          if (syncLevel) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else if (cnt_q == MinLowC) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pulse_d  = 1'b0;
    glitch_d = 1'b0;
    if (enable && (state_q == QUALIFY)) begin
      pulse_d  = syncLevel && (cnt_q == MinHighC);
      glitch_d = !syncLevel;
    end
  end

  assign pulse_out  = pulse_q;
  assign glitch_out = glitch_q;
  assign busy       = busy_q;

`ifdef PULSE_QUALIFIER_WIDTH_MEASURE_EN
  logic [WIDTH_W-1:0] measure_q, measure_d;
  logic [WIDTH_W-1:0] width_q;
  logic               valid_q;
  logic               latchWidth;

  // Bounce highs seen in RELEASE still count toward the measured width.
  always_comb begin
    measure_d = measure_q;
    if (enable && syncLevel) begin
      if (state_q == IDLE) begin
        measure_d = WIDTH_W'(1);
      end else if (measure_q != '1) begin
        measure_d = measure_q + WIDTH_W'(1);
      end
    end
  end

  assign latchWidth = enable && (state_q == RELEASE) && !syncLevel && (cnt_q == MinLowC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      measure_q <= '0;
      width_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      measure_q <= measure_d;
      valid_q   <= latchWidth;
      if (latchWidth) begin
        width_q <= measure_q;
      end
    end
  end

  assign pulse_width = width_q;
  assign width_valid = valid_q;
`endif

endmodule

// File: tb/tb_pulse_qualifier.sv
// Directed self-checking bench for pulse_qualifier (SYNC_STAGES=2, MIN_HIGH=4, MIN_LOW=4).
// Width checks run when PULSE_QUALIFIER_WIDTH_MEASURE_EN is defined.
module tb_pulse_qualifier;

  logic clk = 1'b0;
  logic reset;
  logic signal_in;
  logic enable;
  logic pulse_out;
  logic glitch_out;
  logic busy;
`ifdef PULSE_QUALIFIER_WIDTH_MEASURE_EN
  logic [3:0] pulse_width;
  logic       width_valid;
`endif

  int total = 0;
  int bad   = 0;

  // Edge 1 is the first posedge that samples the most recently driven signal_in level.
  int edgeNum;
  int pulseCount;
  int firstPulseEdge;
  int lastPulseEdge;
  int glitchCount;
  int glitchEdge;
  int busyFallEdge;
  logic busyPrev;
  int validCount;

  always #5 clk = ~clk;

  pulse_qualifier #(
    .SYNC_STAGES(2),
    .MIN_HIGH   (4),
    .MIN_LOW    (4)
`ifdef PULSE_QUALIFIER_WIDTH_MEASURE_EN
    ,
    .WIDTH_W    (4)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .signal_in  (signal_in),
    .enable     (enable),
    .pulse_out  (pulse_out),
    .glitch_out (glitch_out),
    .busy       (busy)
`ifdef PULSE_QUALIFIER_WIDTH_MEASURE_EN
    ,
    .pulse_width(pulse_width),
    .width_valid(width_valid)
`endif
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearCounters();
    edgeNum        = 0;
    pulseCount     = 0;
    firstPulseEdge = -1;
    lastPulseEdge  = -1;
    glitchCount    = 0;
    glitchEdge     = -1;
    busyFallEdge   = -1;
    busyPrev       = busy;
    validCount     = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edgeNum++;
    if (pulse_out === 1'b1) begin
      pulseCount++;
      if (firstPulseEdge < 0) firstPulseEdge = edgeNum;
      lastPulseEdge = edgeNum;
    end
    if (glitch_out === 1'b1) begin
      glitchCount++;
      glitchEdge = edgeNum;
    end
    if (busyPrev && !busy) busyFallEdge = edgeNum;
    busyPrev = busy;
`ifdef PULSE_QUALIFIER_WIDTH_MEASURE_EN
    if (width_valid === 1'b1) validCount++;
`endif
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    signal_in = level;
    repeat (cycles) step();
  endtask

  initial begin
    reset     = 1'b1;
    signal_in = 1'b1;
    enable    = 1'b1;
    clearCounters();
    repeat (3) step();
    checkOutput("reset_pulse", pulse_out, 0);
    checkOutput("reset_glitch", glitch_out, 0);
    checkOutput("reset_busy", busy, 0);
`ifdef PULSE_QUALIFIER_WIDTH_MEASURE_EN
    checkOutput("reset_width", pulse_width, 0);
    checkOutput("reset_valid", width_valid, 0);
`endif
    signal_in = 1'b0;
    reset     = 1'b0;
    repeat (4) step();

    $display("[TB] long pulse");
    clearCounters();
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 20);
    checkOutput("long_pulse_count", pulseCount, 1);
    checkOutput("long_pulse_edge", firstPulseEdge, 7);
    checkOutput("long_busy_fall", busyFallEdge, 27);
    checkOutput("long_glitch_count", glitchCount, 0);

    $display("[TB] short glitch");
    clearCounters();
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 15);
    checkOutput("glitch_count", glitchCount, 1);
    checkOutput("glitch_edge", glitchEdge, 6);
    checkOutput("glitch_no_pulse", pulseCount, 0);
    checkOutput("glitch_busy_fall", busyFallEdge, 6);
    checkOutput("glitch_busy_end", busy, 0);

    $display("[TB] bounce in release");
    clearCounters();
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 12);
    checkOutput("bounce_pulse_count", pulseCount, 1);
    checkOutput("bounce_pulse_edge", firstPulseEdge, 7);
    checkOutput("bounce_busy_fall", busyFallEdge, 29);
    checkOutput("bounce_glitch_count", glitchCount, 0);

    $display("[TB] back-to-back pulses");
    clearCounters();
    applyStimulus(1'b1, 6);
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 6);
    applyStimulus(1'b0, 15);
    checkOutput("b2b_pulse_count", pulseCount, 2);
    checkOutput("b2b_first_edge", firstPulseEdge, 7);
    checkOutput("b2b_spacing", lastPulseEdge - firstPulseEdge, 11);

    $display("[TB] reset during active");
    clearCounters();
    applyStimulus(1'b1, 10);
    checkOutput("rst_active_busy", busy, 1);
    reset = 1'b1;
    #2;
    checkOutput("rst_async_busy", busy, 0);
    checkOutput("rst_async_pulse", pulse_out, 0);
    repeat (2) step();
    reset = 1'b0;
    clearCounters();
    applyStimulus(1'b1, 10);
    checkOutput("rst_requal_count", pulseCount, 1);
    checkOutput("rst_requal_edge", firstPulseEdge, 7);
    applyStimulus(1'b0, 15);
    checkOutput("rst_idle_busy", busy, 0);

    $display("[TB] enable gating");
    clearCounters();
    enable = 1'b0;
    applyStimulus(1'b1, 10);
    checkOutput("en_off_pulse", pulseCount, 0);
    checkOutput("en_off_busy", busy, 0);
    enable = 1'b1;
    clearCounters();
    repeat (6) step();
    checkOutput("en_rise_count", pulseCount, 1);
    checkOutput("en_rise_edge", firstPulseEdge, 5);
    enable = 1'b0;
    clearCounters();
    step();
    checkOutput("en_abort_busy", busy, 0);
    signal_in = 1'b0;
    repeat (4) step();
    enable = 1'b1;
    repeat (4) step();

`ifdef PULSE_QUALIFIER_WIDTH_MEASURE_EN
    $display("[TB] width measure");
    clearCounters();
    applyStimulus(1'b1, 9);
    applyStimulus(1'b0, 15);
    checkOutput("width_9_valid_count", validCount, 1);
    checkOutput("width_9_value", pulse_width, 9);
    clearCounters();
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 15);
    checkOutput("width_sat_valid_count", validCount, 1);
    checkOutput("width_sat_value", pulse_width, 15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
